// File: rtl/nr4sdm_seq_mult.sv
// nr4sdm_seq_mult: sequential signed 16x16 multiplier using NR4SD- recoding, one radix-4 digit per clock
module nr4sdm_seq_mult #(
  parameter int SKIP_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] p
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [15:0] xr, yr;
  logic [31:0] acc, sum;
  logic [2:0] j;
  logic signed [17:0] dig [8];
  logic signed [17:0] xs, pp;
  logic [7:0] nz;
  logic c, np, t, nm, rest_zero, fin;
  always_comb begin
    c = 1'b0;
    np = 1'b0;
    t = 1'b0;
    nm = 1'b0;
    for (int k = 0; k < 7; k++) begin
      np = yr[2*k] ^ c;
      t = yr[2*k] & c;
      nm = yr[2*k+1] ^ t;
      c = yr[2*k+1] | t;
      dig[k] = {17'd0, np} - {16'd0, nm, 1'b0};
    end
    dig[7] = {17'd0, c} + {17'd0, yr[14]} - {16'd0, yr[15], 1'b0};
    for (int k = 0; k < 8; k++) nz[k] = |dig[k];
  end
  assign xs = {{2{xr[15]}}, xr};
  assign pp = dig[j] * xs;
  assign sum = acc + ({{14{pp[17]}}, pp} << {j, 1'b0});
  assign rest_zero = ((nz >> j) >> 1) == 8'd0;
  assign fin = (j == 3'd7) || (SKIP_ZERO != 0 && rest_zero);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (fin ? DONE : RUN) : IDLE;
    ready = state == IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      j <= '0;
      p <= '0;
      xr <= '0;
      yr <= '0;
    end else if (state == IDLE && start) begin
      xr <= x;
      yr <= y;
      acc <= '0;
      j <= '0;
    end else if (state == RUN) begin
      acc <= sum;
      j <= j + 3'd1;
      if (fin) p <= sum;
    end
  end
endmodule

// File: doc/nr4sdm_seq_mult.md
Name: nr4sdm_seq_mult

Overview:
- Sequential signed 16x16 multiplier controller. It recodes the multiplier into 7 NR4SD- digits plus 1 MB top digit and accumulates one radix-4 partial product per clock.
- Owns the digit-index counter, accumulator, FSM and start/done handshake.
- Serves as the area-optimised alternative to the array multipliers, for requesters that tolerate multi-cycle latency.

Parameters:
- SKIP_ZERO, 1: when 1, the FSM finishes as soon as all remaining digits are zero. When 0, it always runs 8 digit cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- x  input  16  multiplicand, two's complement; sampled with start
- y  input  16  multiplier, two's complement; sampled with start, then recoded
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse in DONE; p is valid from this cycle on
- p  output  32  signed product; held until the next accepted start completes

Behaviour:
- Reset (rst=1 at an edge) applies regardless of state:
  - state=IDLE, acc=0, j=0, p=0, done=0, busy=0, ready=1.
  - An operation in progress is aborted; no done pulse is produced.
- Digit recoding of latched y, with carry c0=0:
  - For j=0..6: np_j = y[2j] xor c_j; t = y[2j] and c_j; nm_j = y[2j+1] xor t; c_{j+1} = y[2j+1] or t.
  - digit_j = np_j - 2*nm_j, range {-2..+1}.
  - digit_7 = c_7 + y[14] - 2*y[15], range {-2..+2}.
  - Sum of digit_j*4^j equals signed y exactly.
- FSM states: IDLE, RUN, DONE.
  - IDLE & start: latch x, y; acc<=0; j<=0; go to RUN.
  - IDLE & !start: stay in IDLE.
  - RUN, each edge:
    - acc <= acc + sext32(digit_j*x) << 2j, with 32-bit modular add; the final result is exact.
    - j <= j+1.
    - Go to DONE if j==7, or if SKIP_ZERO=1 and digits j+1..7 are all zero.
    - When going to DONE, p <= the updated acc value (the same sum, not the stale acc).
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency, measured from the start-accepting edge to the first cycle with done=1:
  - SKIP_ZERO=0: 8 cycles fixed.
  - SKIP_ZERO=1: 1..8 cycles, equal to (index of highest nonzero digit)+1, or 1 if all digits are zero.
- Handshake rules:
  - start while in RUN or DONE is ignored and not queued.
  - x and y may change freely after acceptance.
  - Back-to-back operation: start in the cycle after done is accepted, since the FSM is in IDLE then.
  - Minimum period is latency+2 cycles per operation.
- Partial products: digit*x needs 18 bits signed (|-2*-32768| = 65536), sign-extended to 32 before shifting.
- Overflow cannot occur: |x*y| <= 2^30.

Test Plan:
- Reset, then x=3, y=5, SKIP_ZERO=0 -> done 8 cycles after the start edge; p=15 (0x0000000F); ready returns high the cycle after done.
- x=-32768, y=-32768, SKIP_ZERO=0 -> p=0x40000000. Then x=32767, y=-32768 back-to-back (start in the cycle after done) -> p=0xC0008000 (-1073709056).
- SKIP_ZERO=1:
  - y=0, x=1234 -> done 1 cycle after start, p=0.
  - y=-1 (digit_0=-1, others 0), x=100 -> latency 1, p=0xFFFFFF9C.
  - y=4, x=7 -> latency 2, p=28.
- start held high for the whole op, with x/y changed during RUN -> exactly one result for the originally latched operands; the next op starts the cycle after done.
- rst asserted in the 4th RUN cycle of x=3, y=5 -> next cycle: ready=1, busy=0, done=0, p=0; no done pulse follows; a new start then completes normally.
- Random sweep, 10k signed pairs, both SKIP_ZERO values -> p == x*y (32-bit); latency matches the highest-nonzero-digit rule; done is exactly one cycle wide.
